// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, encodings and EX control record for the 16-bit CPU
package cpu_pkg;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_RED    = 4'h2;
    localparam logic [3:0] OP_XOR    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LHB    = 4'hA;
    localparam logic [3:0] OP_LLB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_BR     = 4'hD;
    localparam logic [3:0] OP_PCS    = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

    localparam logic [15:0] NOP = 16'h0000;

    localparam logic [2:0] FWD_NONE = 3'b000;
    localparam logic [2:0] FWD_MEM  = 3'b010;
    localparam logic [2:0] FWD_WB   = 3'b001;

    // Everything the EX stage latches besides the raw data words; all-zero is a bubble.
    typedef struct packed {
        logic       valid;
        logic       ld_byte;
        logic       mem_op;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       hlt;
        logic [3:0] rd;
        logic [2:0] fwd_a;
        logic [2:0] fwd_b;
    } ex_ctrl_t;

    function automatic logic [3:0] opcode_of(input logic [15:0] instr);
        return instr[15:12];
    endfunction

endpackage

// File: rtl/id_decode_src.sv
// rtl/id_decode_src.sv - combinational decode of register fields, operand use and control flags
module id_decode_src
    import cpu_pkg::*;
(
    input  logic [15:0] instr,
    output logic [3:0]  src_a,
    output logic [3:0]  src_b,
    output logic [3:0]  rd,
    output logic        use_a,
    output logic        use_b,
    output logic        reg_write,
    output logic        ld_byte,
    output logic        mem_op,
    output logic        mem_read,
    output logic        mem_write,
    output logic        hlt
);

    logic       writes_rd;
    logic [3:0] op;

    assign op = opcode_of(instr);
    assign rd = instr[11:8];
    // R0 is hardwired zero, so a write to it is never a real producer.
    assign reg_write = writes_rd & (rd != 4'h0);

    always_comb begin
        src_a     = instr[7:4];
        src_b     = instr[3:0];
        use_a     = 1'b0;
        use_b     = 1'b0;
        writes_rd = 1'b0;
        ld_byte   = 1'b0;
        mem_op    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        hlt       = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_RED, OP_XOR, OP_PADDSB: begin
                use_a     = 1'b1;
                use_b     = 1'b1;
                writes_rd = 1'b1;
            end
            OP_SLL, OP_SRA, OP_ROR: begin
                use_a     = 1'b1;
                writes_rd = 1'b1;
            end
            OP_LW: begin
                use_a     = 1'b1;
                writes_rd = 1'b1;
                mem_op    = 1'b1;
                mem_read  = 1'b1;
            end
            OP_SW: begin
                use_a     = 1'b1;
                use_b     = 1'b1;
                src_b     = instr[11:8];
                mem_op    = 1'b1;
                mem_write = 1'b1;
            end
            OP_LHB, OP_LLB: begin
                // Byte loads read-modify-write the destination register itself.
                use_a     = 1'b1;
                src_a     = instr[11:8];
                writes_rd = 1'b1;
                ld_byte   = 1'b1;
            end
            OP_BR:   use_a     = 1'b1;
            OP_PCS:  writes_rd = 1'b1;
            OP_HLT:  hlt       = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with forwarding selects, load-use and MEM tracking
module id_ex_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_stall,
    input  logic        flush,
    input  logic        valid_ID,
    input  logic [15:0] instr_ID,
    input  logic [15:0] RegData1_ID,
    input  logic [15:0] RegData2_ID,
    input  logic [15:0] pcs_ID,
    output logic [15:0] instr_EX,
    output logic [15:0] RegData1_EX,
    output logic [15:0] RegData2_EX,
    output logic [15:0] pcs_EX,
    output logic        valid_EX,
    output logic        LdByte_EX,
    output logic        MemOp_EX,
    output logic        MemRead_EX,
    output logic        MemWrite_EX,
    output logic        RegWrite_EX,
    output logic        hlt_EX,
    output logic [3:0]  rd_EX,
    output logic [2:0]  ForwardA,
    output logic [2:0]  ForwardB,
    output logic        stall_ID
);

    logic [3:0] src_a_id, src_b_id, rd_id;
    logic       use_a_id, use_b_id, reg_write_id;
    logic       ld_byte_id, mem_op_id, mem_read_id, mem_write_id, hlt_id;

    id_decode_src u_decode (
        .instr     (instr_ID),
        .src_a     (src_a_id),
        .src_b     (src_b_id),
        .rd        (rd_id),
        .use_a     (use_a_id),
        .use_b     (use_b_id),
        .reg_write (reg_write_id),
        .ld_byte   (ld_byte_id),
        .mem_op    (mem_op_id),
        .mem_read  (mem_read_id),
        .mem_write (mem_write_id),
        .hlt       (hlt_id)
    );

    logic [15:0] instr_q, instr_d;
    logic [15:0] data1_q, data1_d;
    logic [15:0] data2_q, data2_d;
    logic [15:0] pcs_q, pcs_d;
    ex_ctrl_t    ctrl_q, ctrl_d;
    logic [3:0]  rd_mem_q, rd_mem_d;
    logic        reg_write_mem_q, reg_write_mem_d;

    logic       a_hit_ex, b_hit_ex, a_hit_mem, b_hit_mem;
    logic       ex_is_load, load_use;
    logic [2:0] fwd_a_id, fwd_b_id;

    // The EX producer is newer than the MEM one, so it masks the MEM match.
    assign a_hit_ex  = use_a_id & ctrl_q.reg_write & ctrl_q.valid & (src_a_id == ctrl_q.rd);
    assign b_hit_ex  = use_b_id & ctrl_q.reg_write & ctrl_q.valid & (src_b_id == ctrl_q.rd);
    assign a_hit_mem = use_a_id & reg_write_mem_q & (src_a_id == rd_mem_q) & ~a_hit_ex;
    assign b_hit_mem = use_b_id & reg_write_mem_q & (src_b_id == rd_mem_q) & ~b_hit_ex;
    assign fwd_a_id  = {1'b0, a_hit_ex, a_hit_mem};
    assign fwd_b_id  = {1'b0, b_hit_ex, b_hit_mem};

    assign ex_is_load = ctrl_q.valid & (opcode_of(instr_q) == OP_LW) & ctrl_q.reg_write;
    assign load_use   = valid_ID & ex_is_load & (a_hit_ex | b_hit_ex);
    // On a flush the ID instruction is squashed upstream, so holding it is pointless.
    assign stall_ID   = load_use & ~flush;

    always_comb begin
        instr_d         = instr_q;
        data1_d         = data1_q;
        data2_d         = data2_q;
        pcs_d           = pcs_q;
        ctrl_d          = ctrl_q;
        rd_mem_d        = rd_mem_q;
        reg_write_mem_d = reg_write_mem_q;
        if (!mem_stall) begin
            rd_mem_d        = ctrl_q.rd;
            reg_write_mem_d = ctrl_q.reg_write;
            if (flush || load_use || !valid_ID) begin
                instr_d = NOP;
                data1_d = 16'h0000;
                data2_d = 16'h0000;
                pcs_d   = 16'h0000;
                ctrl_d  = '0;
            end else begin
                instr_d          = instr_ID;
                data1_d          = RegData1_ID;
                data2_d          = RegData2_ID;
                pcs_d            = pcs_ID;
                ctrl_d.valid     = 1'b1;
                ctrl_d.ld_byte   = ld_byte_id;
                ctrl_d.mem_op    = mem_op_id;
                ctrl_d.mem_read  = mem_read_id;
                ctrl_d.mem_write = mem_write_id;
                ctrl_d.reg_write = reg_write_id;
                ctrl_d.hlt       = hlt_id;
                ctrl_d.rd        = rd_id;
                ctrl_d.fwd_a     = fwd_a_id;
                ctrl_d.fwd_b     = fwd_b_id;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q         <= NOP;
            data1_q         <= 16'h0000;
            data2_q         <= 16'h0000;
            pcs_q           <= 16'h0000;
            ctrl_q          <= '0;
            rd_mem_q        <= 4'h0;
            reg_write_mem_q <= 1'b0;
        end else begin
            instr_q         <= instr_d;
            data1_q         <= data1_d;
            data2_q         <= data2_d;
            pcs_q           <= pcs_d;
            ctrl_q          <= ctrl_d;
            rd_mem_q        <= rd_mem_d;
            reg_write_mem_q <= reg_write_mem_d;
        end
    end

    assign instr_EX    = instr_q;
    assign RegData1_EX = data1_q;
    assign RegData2_EX = data2_q;
    assign pcs_EX      = pcs_q;
    assign valid_EX    = ctrl_q.valid;
    assign LdByte_EX   = ctrl_q.ld_byte;
    assign MemOp_EX    = ctrl_q.mem_op;
    assign MemRead_EX  = ctrl_q.mem_read;
    assign MemWrite_EX = ctrl_q.mem_write;
    assign RegWrite_EX = ctrl_q.reg_write;
    assign hlt_EX      = ctrl_q.hlt;
    assign rd_EX       = ctrl_q.rd;
    assign ForwardA    = ctrl_q.fwd_a;
    assign ForwardB    = ctrl_q.fwd_b;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed and randomized checks of id_ex_stage against an instruction-level model
module tb_id_ex_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, mem_stall, flush, valid_ID;
    logic [15:0] instr_ID, RegData1_ID, RegData2_ID, pcs_ID;
    logic [15:0] instr_EX, RegData1_EX, RegData2_EX, pcs_EX;
    logic        valid_EX, LdByte_EX, MemOp_EX, MemRead_EX, MemWrite_EX, RegWrite_EX, hlt_EX;
    logic [3:0]  rd_EX;
    logic [2:0]  ForwardA, ForwardB;
    logic        stall_ID;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .mem_stall(mem_stall), .flush(flush), .valid_ID(valid_ID),
        .instr_ID(instr_ID), .RegData1_ID(RegData1_ID), .RegData2_ID(RegData2_ID), .pcs_ID(pcs_ID),
        .instr_EX(instr_EX), .RegData1_EX(RegData1_EX), .RegData2_EX(RegData2_EX), .pcs_EX(pcs_EX),
        .valid_EX(valid_EX), .LdByte_EX(LdByte_EX), .MemOp_EX(MemOp_EX), .MemRead_EX(MemRead_EX),
        .MemWrite_EX(MemWrite_EX), .RegWrite_EX(RegWrite_EX), .hlt_EX(hlt_EX), .rd_EX(rd_EX),
        .ForwardA(ForwardA), .ForwardB(ForwardB), .stall_ID(stall_ID)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    int fail_cnt = 0;

    // Model: the instruction sitting in EX plus the destination of the one in MEM.
    logic        m_valid;
    logic [15:0] m_instr, m_d1, m_d2, m_pcs;
    logic [2:0]  m_fa, m_fb;
    logic [3:0]  m_mem_rd;
    logic        m_mem_rw;
    logic        last_stall;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic writes(input logic [15:0] i);
        int op;
        op = int'(i[15:12]);
        return (op <= 8 || op == 10 || op == 11 || op == 14) && i[11:8] != 4'h0;
    endfunction
    function automatic logic uses_a(input logic [15:0] i);
        int op;
        op = int'(i[15:12]);
        return op <= 11 || op == 13;
    endfunction
    function automatic logic uses_b(input logic [15:0] i);
        int op;
        op = int'(i[15:12]);
        return op <= 3 || op == 7 || op == 9;
    endfunction
    function automatic logic [3:0] reg_a(input logic [15:0] i);
        return (i[15:12] == 4'hA || i[15:12] == 4'hB) ? i[11:8] : i[7:4];
    endfunction
    function automatic logic [3:0] reg_b(input logic [15:0] i);
        return (i[15:12] == 4'h9) ? i[11:8] : i[3:0];
    endfunction

    function automatic logic [2:0] model_fwd(input logic used, input logic [3:0] src);
        logic from_ex, from_mem;
        from_ex  = used && m_valid && writes(m_instr) && src == m_instr[11:8];
        from_mem = used && m_mem_rw && src == m_mem_rd && !from_ex;
        return {1'b0, from_ex, from_mem};
    endfunction

    function automatic logic model_load_use(input logic v, input logic [15:0] i);
        logic [3:0] r;
        r = m_instr[11:8];
        return v && m_valid && m_instr[15:12] == 4'h8 && writes(m_instr) &&
               ((uses_a(i) && reg_a(i) == r) || (uses_b(i) && reg_b(i) == r));
    endfunction

    task automatic model_clear();
        m_valid = 0; m_instr = 16'h0; m_d1 = 16'h0; m_d2 = 16'h0; m_pcs = 16'h0;
        m_fa = 3'b0; m_fb = 3'b0; m_mem_rd = 4'h0; m_mem_rw = 0; last_stall = 0;
    endtask

    task automatic check_outputs(input string pfx);
        int op;
        op = int'(m_instr[15:12]);
        chk({pfx, ".instr_EX"}, instr_EX, m_valid ? m_instr : 16'h0);
        chk({pfx, ".RegData1_EX"}, RegData1_EX, m_valid ? m_d1 : 16'h0);
        chk({pfx, ".RegData2_EX"}, RegData2_EX, m_valid ? m_d2 : 16'h0);
        chk({pfx, ".pcs_EX"}, pcs_EX, m_valid ? m_pcs : 16'h0);
        chk({pfx, ".valid_EX"}, 16'(valid_EX), 16'(m_valid));
        chk({pfx, ".LdByte_EX"}, 16'(LdByte_EX), 16'(m_valid && (op == 10 || op == 11)));
        chk({pfx, ".MemOp_EX"}, 16'(MemOp_EX), 16'(m_valid && (op == 8 || op == 9)));
        chk({pfx, ".MemRead_EX"}, 16'(MemRead_EX), 16'(m_valid && op == 8));
        chk({pfx, ".MemWrite_EX"}, 16'(MemWrite_EX), 16'(m_valid && op == 9));
        chk({pfx, ".RegWrite_EX"}, 16'(RegWrite_EX), 16'(m_valid && writes(m_instr)));
        chk({pfx, ".hlt_EX"}, 16'(hlt_EX), 16'(m_valid && op == 15));
        chk({pfx, ".rd_EX"}, 16'(rd_EX), 16'(m_valid ? m_instr[11:8] : 4'h0));
        chk({pfx, ".ForwardA"}, 16'(ForwardA), 16'(m_valid ? m_fa : 3'b0));
        chk({pfx, ".ForwardB"}, 16'(ForwardB), 16'(m_valid ? m_fb : 3'b0));
    endtask

    // Called at a falling edge; drives one cycle of ID inputs and checks both sides of the edge.
    task automatic cycle(input string pfx, input logic v, input logic [15:0] ins,
                         input logic fl, input logic ms);
        logic        lu;
        logic [2:0]  fa, fb;
        logic [15:0] d1, d2, pc;
        d1 = 16'($urandom); d2 = 16'($urandom); pc = 16'($urandom);
        valid_ID = v; instr_ID = ins; flush = fl; mem_stall = ms;
        RegData1_ID = d1; RegData2_ID = d2; pcs_ID = pc;
        #1;
        lu = model_load_use(v, ins);
        fa = model_fwd(uses_a(ins), reg_a(ins));
        fb = model_fwd(uses_b(ins), reg_b(ins));
        chk({pfx, ".stall_ID"}, 16'(stall_ID), 16'(lu && !fl));
        last_stall = lu && !fl;
        if (!ms) begin
            m_mem_rd = m_valid ? m_instr[11:8] : 4'h0;
            m_mem_rw = m_valid && writes(m_instr);
            if (fl || lu || !v) begin
                m_valid = 0; m_instr = 16'h0;
            end else begin
                m_valid = 1; m_instr = ins; m_d1 = d1; m_d2 = d2; m_pcs = pc;
                m_fa = fa; m_fb = fb;
            end
        end
        @(posedge clk);
        #1;
        check_outputs(pfx);
        @(negedge clk);
    endtask

    task automatic idle(input string pfx);
        cycle(pfx, 1'b0, 16'h0, 1'b0, 1'b0);
        cycle(pfx, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    logic [15:0] r_ins;
    logic        r_v, r_fl, r_ms, prev_hold;

    initial begin
        rst = 1; mem_stall = 0; flush = 0; valid_ID = 0;
        instr_ID = 16'h0; RegData1_ID = 16'h0; RegData2_ID = 16'h0; pcs_ID = 16'h0;
        model_clear();
        #2;
        check_outputs("reset");
        chk("reset.stall_ID", 16'(stall_ID), 16'h0);
        @(negedge clk); @(negedge clk);
        rst = 0;

        // EX->EX forwarding
        cycle("exex0", 1, 16'h0312, 0, 0);
        cycle("exex1", 1, 16'h1435, 0, 0);
        chk("exex.ForwardA", 16'(ForwardA), 16'(FWD_MEM));
        chk("exex.ForwardB", 16'(ForwardB), 16'(FWD_NONE));
        idle("gap0");

        // MEM->EX forwarding, then newer producer wins
        cycle("memex0", 1, 16'h0312, 0, 0);
        cycle("memex1", 1, 16'h0678, 0, 0);
        cycle("memex2", 1, 16'h1435, 0, 0);
        chk("memex.ForwardA", 16'(ForwardA), 16'(FWD_WB));
        cycle("newer0", 1, 16'h0312, 0, 0);
        cycle("newer1", 1, 16'h0378, 0, 0);
        cycle("newer2", 1, 16'h1435, 0, 0);
        chk("newer.ForwardA", 16'(ForwardA), 16'(FWD_MEM));
        idle("gap1");

        // Load-use: one bubble, then consumer with WB forwarding on both operands
        cycle("lu0", 1, 16'h8312, 0, 0);
        cycle("lu1", 1, 16'h0533, 0, 0);
        chk("lu.bubble_valid", 16'(valid_EX), 16'h0);
        chk("lu.bubble_instr", instr_EX, 16'h0000);
        cycle("lu2", 1, 16'h0533, 0, 0);
        chk("lu.stall_released", 16'(stall_ID), 16'h0);
        chk("lu.ForwardA", 16'(ForwardA), 16'(FWD_WB));
        chk("lu.ForwardB", 16'(ForwardB), 16'(FWD_WB));
        idle("gap2");

        // Flush during load-use, then writes to R0 never forward
        cycle("flu0", 1, 16'h8312, 0, 0);
        cycle("flu1", 1, 16'h0533, 1, 0);
        chk("flu.bubble_valid", 16'(valid_EX), 16'h0);
        cycle("r0_0", 1, 16'h0012, 0, 0);
        cycle("r0_1", 1, 16'h1405, 0, 0);
        chk("r0.ForwardA", 16'(ForwardA), 16'(FWD_NONE));
        idle("gap3");

        // Two LW to the same rd: younger one forwards
        cycle("ll0", 1, 16'h8312, 0, 0);
        cycle("ll1", 1, 16'h8345, 0, 0);
        cycle("ll2", 1, 16'h0633, 0, 0);
        cycle("ll3", 1, 16'h0633, 0, 0);
        chk("ll.ForwardA", 16'(ForwardA), 16'(FWD_WB));
        idle("gap4");

        // mem_stall hold for three cycles with ADD in EX
        cycle("ms0", 1, 16'h0312, 0, 0);
        for (int k = 0; k < 3; k++) cycle("ms_hold", 1, 16'h1435, 0, 1);
        chk("ms.instr_held", instr_EX, 16'h0312);
        cycle("ms_rel", 1, 16'h1435, 0, 0);
        chk("ms.ForwardA", 16'(ForwardA), 16'(FWD_MEM));

        // Asynchronous reset mid-stream
        cycle("pre_rst", 1, 16'h8312, 0, 0);
        #2;
        rst = 1;
        #1;
        model_clear();
        check_outputs("midrst");
        chk("midrst.stall_ID", 16'(stall_ID), 16'h0);
        @(negedge clk);
        rst = 0;

        // Randomized traffic over a small register window so hazards are frequent
        prev_hold = 0;
        r_ins = 16'h0; r_v = 0;
        for (int n = 0; n < 400; n++) begin
            if (!prev_hold) begin
                r_v   = ($urandom_range(0, 7) != 0);
                r_ins = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
                         4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
            end
            r_fl = ($urandom_range(0, 9) == 0);
            r_ms = ($urandom_range(0, 5) == 0);
            cycle("rand", r_v, r_ins, r_fl, r_ms);
            prev_hold = last_stall || r_ms;
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline boundary of the 5-stage 16-bit CPU. Captures decoded instruction data from ID, holds it on memory stalls, inserts bubbles on flush or load-use hazard, and produces the registered forwarding selects that the execute-stage ALU control consumes. It also tracks the destination register of the instruction one stage ahead (MEM), so all forwarding and hazard decisions are made in one place.

## Interface
Parameters:
- none (opcodes and encodings come from the shared package)

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- mem_stall  in  1  freeze all state; has priority over every other control
- flush  in  1  branch taken in EX; the next EX content is a bubble
- valid_ID  in  1  instr_ID holds a real instruction
- instr_ID  in  16  instruction in ID
- RegData1_ID, RegData2_ID  in  16 each  register file read ports 1 and 2
- pcs_ID  in  16  PC+2 of the ID instruction
- instr_EX, RegData1_EX, RegData2_EX, pcs_EX  out  16 each  registered copies
- valid_EX, LdByte_EX, MemOp_EX, MemRead_EX, MemWrite_EX, RegWrite_EX, hlt_EX  out  1 each  registered decode flags
- rd_EX  out  4  destination register of the EX instruction
- ForwardA, ForwardB  out  3 each  operand select: bit1 = EX/MEM result, bit0 = MEM/WB WriteData, bit2 = 0
- stall_ID  out  1  hold PC and IF/ID (combinational)

## Operation
- Opcode is instr[15:12]:
  - 0 ADD, 1 SUB, 2 RED, 3 XOR, 4 SLL, 5 SRA, 6 ROR, 7 PADDSB
  - 8 LW, 9 SW, A LHB, B LLB
  - C B, D BR, E PCS, F HLT
- Register fields:
  - rd = [11:8].
  - srcA = [11:8] for LHB/LLB, otherwise [7:4].
  - srcB = [11:8] for SW, otherwise [3:0].
- Operand use:
  - useA for opcodes 0–B and D.
  - useB for opcodes 0–3, 7 and 9.
- RegWrite for opcodes 0–8, A, B and E, forced to 0 when rd = 0.
- Other decode flags:
  - LdByte for A and B.
  - MemOp and MemRead for LW; MemOp and MemWrite for SW.
  - hlt for F.
- Internal MEM tracker holds rd_MEM and RegWrite_MEM. It loads rd_EX and RegWrite_EX every non-stalled edge.
- Forwarding is computed in ID and registered on transfer:
  - ForwardX[1] = useX & RegWrite_EX & valid_EX & (srcX == rd_EX).
  - ForwardX[0] = useX & RegWrite_MEM & (srcX == rd_MEM) & ~ForwardX[1]. The newer producer wins.
- Load-use hazard:
  - Condition: valid_ID, valid_EX, EX opcode is LW, RegWrite_EX, and a used src of ID equals rd_EX.
  - stall_ID = load-use & ~flush.
- Edge priority:
  1. rst: all registers cleared.
  2. mem_stall: hold everything, including the MEM tracker.
  3. flush or load-use: EX loads a bubble.
  4. Otherwise: EX loads ID, gated by valid_ID.
- Bubble: instr_EX = 16'h0000, all flags 0, rd_EX = 0, ForwardA = ForwardB = 0.

## Timing
- Data latency is 1 cycle from ID to EX.
- All outputs reset to 0 immediately on rst assertion, including mid-operation. stall_ID is 0 under reset because valid_EX = 0.
- Load-use costs exactly one bubble. The consumer enters EX when the LW is in WB, with Forward bit0 set.
- flush and load-use in the same cycle: one bubble, stall_ID = 0. The ID instruction is squashed upstream.
- mem_stall together with flush or load-use: hold. The decision is re-evaluated on the first cycle without mem_stall.
- A chain of two LW writing the same rd followed by a consumer forwards from the younger LW only.
- Writes to R0 never forward and never stall.

## Structure
- cpu_pkg holds:
  - opcode localparams OP_ADD … OP_HLT
  - NOP = 16'h0000
  - FWD_NONE = 3'b000, FWD_MEM = 3'b010, FWD_WB = 3'b001
- One sub-module, id_decode_src (combinational), produces srcA, srcB, useA, useB, rd, RegWrite and the memory flags from instr. It is instantiated once for ID. EX flags are registered outputs of that instance.
- id_ex_stage contains the registers, the MEM tracker, the comparators and the priority logic.

## Test plan
- Reset: assert rst mid-stream → every output, including ForwardA/B and stall_ID, reads 0 in the same cycle.
- EX→EX forwarding: 0x0312 then 0x1435 back-to-back → SUB in EX with ForwardA = 3'b010, ForwardB = 3'b000.
- MEM→EX forwarding: 0x0312, 0x0678, 0x1435 → ForwardA = 3'b001. With 0x0312, 0x0378, 0x1435, the newer producer wins → ForwardA = 3'b010.
- Load-use stall: 0x8312 then 0x0533:
  - stall_ID = 1 for exactly one cycle.
  - EX shows valid_EX = 0, instr_EX = 0x0000.
  - Next cycle: 0x0533 in EX with ForwardA = ForwardB = 3'b001.
- Flush during load-use: 0x8312 then 0x0533 with flush = 1 → bubble, stall_ID = 0. With 0x0012 then 0x1405 → no forwarding, no stall.
- mem_stall: hold 3 cycles with 0x0312 in EX → all EX outputs unchanged. On release, 0x1435 enters with ForwardA = 3'b010.
